fc_argmax: RTL

FC_ARGMAX -- requirements
Module: fc_argmax

---
 rtl/fc_argmax.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fc_argmax.sv
// fc_argmax: argmax over 64 FC-layer neurons delivered as 4 beats of 16 unsigned 18-bit lanes.
// Optional macro FC_ARGMAX_TOP2_EN adds the runner-up neuron on cls2/max_val2.
module fc_argmax (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_vld,
    input  logic [15:0][17:0] din,
    input  logic              tx_done,
    output logic [5:0]        cls,
    output logic [17:0]       max_val,
`ifdef FC_ARGMAX_TOP2_EN
    output logic [5:0]        cls2,
    output logic [17:0]       max_val2,
`endif
    output logic              done,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Reduction node: best lane (and runner-up when enabled), ordered by value desc, index asc.
    typedef struct packed {
        logic [17:0] m1;
        logic [3:0]  i1;
`ifdef FC_ARGMAX_TOP2_EN
        logic [17:0] m2;
        logic [3:0]  i2;
`endif
    } node_t;

    // Leaf pairs yield both the best lane and the runner-up directly from the two inputs.
    function automatic node_t leaf_pair(input logic [17:0] va, input logic [3:0] ia,
                                        input logic [17:0] vb, input logic [3:0] ib);
        node_t n;
        if (va >= vb) begin
            n.m1 = va;
            n.i1 = ia;
`ifdef FC_ARGMAX_TOP2_EN
            n.m2 = vb;
            n.i2 = ib;
`endif
        end else begin
            n.m1 = vb;
            n.i1 = ib;
`ifdef FC_ARGMAX_TOP2_EN
            n.m2 = va;
            n.i2 = ia;
`endif
        end
        return n;
    endfunction

    // Node a always covers lower lane indices than b, so a wins every tie.
    function automatic node_t merge_node(input node_t a, input node_t b);
        node_t n;
        if (a.m1 >= b.m1) begin
            n.m1 = a.m1;
            n.i1 = a.i1;
`ifdef FC_ARGMAX_TOP2_EN
            if (a.m2 >= b.m1) begin
                n.m2 = a.m2;
                n.i2 = a.i2;
            end else begin
                n.m2 = b.m1;
                n.i2 = b.i1;
            end
`endif
        end else begin
            n.m1 = b.m1;
            n.i1 = b.i1;
`ifdef FC_ARGMAX_TOP2_EN
            if (a.m1 >= b.m2) begin
                n.m2 = a.m1;
                n.i2 = a.i1;
            end else begin
                n.m2 = b.m2;
                n.i2 = b.i2;
            end
`endif
        end
        return n;
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_beat;
    logic [1:0]  w_beat_nxt;
    logic        w_accept;
    logic [5:0]  r_cls;
    logic [5:0]  w_cls_nxt;
    logic [17:0] r_max;
    logic [17:0] w_max_nxt;
    logic        r_done;
    logic        r_busy;
`ifdef FC_ARGMAX_TOP2_EN
    logic [5:0]  r_cls2;
    logic [5:0]  w_cls2_nxt;
    logic [17:0] r_max2;
    logic [17:0] w_max2_nxt;
`endif

    node_t w_l1 [8];
    node_t w_l2 [4];
    node_t w_l3 [2];
    node_t w_red;

    // Four-level compare tree reducing the current beat's 16 lanes.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_l1[k] = leaf_pair(din[2*k], 4'(2*k), din[2*k+1], 4'(2*k+1));
        end
        for (int k = 0; k < 4; k++) begin
            w_l2[k] = merge_node(w_l1[2*k], w_l1[2*k+1]);
        end
        for (int k = 0; k < 2; k++) begin
            w_l3[k] = merge_node(w_l2[2*k], w_l2[2*k+1]);
        end
        w_red = merge_node(w_l3[0], w_l3[1]);
    end

    // Next-state logic; tx_done overrides any beat arriving in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_accept    = 1'b0;
        if (tx_done) begin
            w_state_nxt = ST_IDLE;
            w_beat_nxt  = 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (din_vld) begin
                        w_accept    = 1'b1;
                        w_beat_nxt  = 2'd1;
                        w_state_nxt = ST_ACC;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_ACC: begin
                    if (din_vld) begin
                        w_accept   = 1'b1;
                        w_beat_nxt = r_beat + 2'd1;
                        if (r_beat == 2'd3) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_state_nxt = ST_ACC;
                        end
                    end else begin
                        w_state_nxt = ST_ACC;
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_DONE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_beat_nxt  = 2'd0;
                end
            endcase
        end
    end

    // Running top-1 (and top-2) merge; earlier beats hold lower indices and win ties.
    always_comb begin
        w_cls_nxt = r_cls;
        w_max_nxt = r_max;
`ifdef FC_ARGMAX_TOP2_EN
        w_cls2_nxt = r_cls2;
        w_max2_nxt = r_max2;
`endif
        if (w_accept && (r_state == ST_IDLE)) begin
            w_max_nxt = w_red.m1;
            w_cls_nxt = {2'b00, w_red.i1};
`ifdef FC_ARGMAX_TOP2_EN
            w_max2_nxt = w_red.m2;
            w_cls2_nxt = {2'b00, w_red.i2};
`endif
        end else if (w_accept) begin
            if (w_red.m1 > r_max) begin
                w_max_nxt = w_red.m1;
                w_cls_nxt = {r_beat, w_red.i1};
`ifdef FC_ARGMAX_TOP2_EN
                if (r_max >= w_red.m2) begin
                    w_max2_nxt = r_max;
                    w_cls2_nxt = r_cls;
                end else begin
                    w_max2_nxt = w_red.m2;
                    w_cls2_nxt = {r_beat, w_red.i2};
                end
`endif
            end else begin
                w_max_nxt = r_max;
`ifdef FC_ARGMAX_TOP2_EN
                if (w_red.m1 > r_max2) begin
                    w_max2_nxt = w_red.m1;
                    w_cls2_nxt = {r_beat, w_red.i1};
                end else begin
                    w_max2_nxt = r_max2;
                end
`endif
            end
        end else begin
            w_cls_nxt = r_cls;
        end
    end

    // State and result registers; rst outranks tx_done and din_vld.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_beat  <= 2'd0;
            r_cls   <= 6'd0;
            r_max   <= 18'd0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
`ifdef FC_ARGMAX_TOP2_EN
            r_cls2  <= 6'd0;
            r_max2  <= 18'd0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            r_cls   <= w_cls_nxt;
            r_max   <= w_max_nxt;
            r_done  <= (w_state_nxt == ST_DONE);
            r_busy  <= (w_state_nxt == ST_ACC);
`ifdef FC_ARGMAX_TOP2_EN
            r_cls2  <= w_cls2_nxt;
            r_max2  <= w_max2_nxt;
`endif
        end
    end

    assign cls     = r_cls;
    assign max_val = r_max;
    assign done    = r_done;
    assign busy    = r_busy;
`ifdef FC_ARGMAX_TOP2_EN
    assign cls2     = r_cls2;
    assign max_val2 = r_max2;
`endif

endmodule
